// File: rtl/tmr_mch_pkg.sv
// tmr_mch_pkg -- shared definitions for the multi-channel timer.
//   Register byte offsets, CTRL/CHCTRL bit positions and the channel MODE
//   encoding. Imported by tmr_mch and tmr_mch_ch.
package tmr_mch_pkg;

    localparam logic [7:0] ADDR_CTRL    = 8'h00;
    localparam logic [7:0] ADDR_PSCR    = 8'h04;
    localparam logic [7:0] ADDR_CNT     = 8'h08;
    localparam logic [7:0] ADDR_RELOAD  = 8'h0C;
    localparam logic [7:0] ADDR_STAT    = 8'h10;
    // Channel n: CHCTRL at ADDR_CH_BASE + 8n, CHVAL at ADDR_CH_BASE + 8n + 4
    localparam logic [7:0] ADDR_CH_BASE = 8'h20;

    localparam int CTRL_EN    = 0;
    localparam int CTRL_OSM   = 1;
    localparam int CTRL_OVIE  = 2;
    localparam int CHCTRL_IE  = 2;

    typedef enum logic [1:0] {
        MODE_OFF      = 2'b00,
        MODE_CMP      = 2'b01,
        MODE_CAP_RISE = 2'b10,
        MODE_CAP_FALL = 2'b11
    } ch_mode_e;

endpackage

// File: rtl/tmr_mch_ch.sv
// tmr_mch_ch -- one capture/compare channel of the timer.
//   clk_i, rst_i     : clock, synchronous active-high reset
//   cnt_i, tick_i    : shared counter value and effective count tick
//   ctrl_wr_i        : CHCTRL write strobe, ctrl_wdata_i = {IE, MODE}
//   val_wr_i         : CHVAL write strobe, val_wdata_i = new value
//   flag_clr_i       : W1C request for this channel's CHIF
//   capch_i          : asynchronous capture pin
//   chctrl_o/chval_o : register readback
//   chif_o           : channel interrupt flag
//   pwm_o            : registered compare output
//   irq_o            : chif & ie (registered again by the top)
module tmr_mch_ch #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [CNT_WIDTH-1:0] cnt_i,
    input  logic                 tick_i,
    input  logic                 ctrl_wr_i,
    input  logic [2:0]           ctrl_wdata_i,
    input  logic                 val_wr_i,
    input  logic [CNT_WIDTH-1:0] val_wdata_i,
    input  logic                 flag_clr_i,
    input  logic                 capch_i,
    output logic [2:0]           chctrl_o,
    output logic [CNT_WIDTH-1:0] chval_o,
    output logic                 chif_o,
    output logic                 pwm_o,
    output logic                 irq_o
);
    import tmr_mch_pkg::*;

    ch_mode_e             mode;
    logic                 ie;
    logic [CNT_WIDTH-1:0] chval;
    logic                 chif;
    logic                 pwm;
    logic                 sync_p0, sync_p1, dly_p2, cap_vld_p2;
    logic                 is_cap, edge_hit, cmp_hit, cap_set;

    assign is_cap  = (mode == MODE_CAP_RISE) || (mode == MODE_CAP_FALL);
    assign cmp_hit = tick_i && (mode == MODE_CMP) && (cnt_i == chval);
    // Mode is re-checked at load so a capture in flight dies if the
    // channel is switched away from capture meanwhile.
    assign cap_set = cap_vld_p2 && is_cap;

    always_comb begin
        edge_hit = 1'b0;
        case (mode)
            MODE_CAP_RISE: edge_hit = sync_p1 & ~dly_p2;
            MODE_CAP_FALL: edge_hit = ~sync_p1 & dly_p2;
            default:       edge_hit = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mode       <= MODE_OFF;
            ie         <= 1'b0;
            chval      <= '0;
            chif       <= 1'b0;
            pwm        <= 1'b0;
            sync_p0    <= 1'b0;
            sync_p1    <= 1'b0;
            dly_p2     <= 1'b0;
            cap_vld_p2 <= 1'b0;
        end else begin
            // p0/p1: two-flop synchroniser for the asynchronous pin
            sync_p0 <= capch_i;
            sync_p1 <= sync_p0;
            // p2: previous synchronised level and registered edge pulse
            dly_p2     <= sync_p1;
            cap_vld_p2 <= edge_hit;

            if (ctrl_wr_i) begin
                mode <= ch_mode_e'(ctrl_wdata_i[1:0]);
                ie   <= ctrl_wdata_i[CHCTRL_IE];
            end

            // Hardware capture beats a simultaneous software write
            if (cap_set)
                chval <= cnt_i;
            else if (val_wr_i)
                chval <= val_wdata_i;

            // Hardware set beats a simultaneous W1C
            chif <= (chif & ~flag_clr_i) | cap_set | cmp_hit;

            pwm <= (mode == MODE_CMP) && (cnt_i < chval);
        end
    end

    assign chctrl_o = {ie, mode};
    assign chval_o  = chval;
    assign chif_o   = chif;
    assign pwm_o    = pwm;
    assign irq_o    = chif & ie;

endmodule

// File: rtl/tmr_mch.sv
// tmr_mch -- prescaled up-counter with reload, one-shot mode and
// CH_NUM capture/compare channels behind a simple register bus.
//   clk_i, rst_i : clock, synchronous active-high reset
//   addr_i       : byte address (bits [1:0] ignored)
//   wr_i/wdata_i : write strobe and data
//   rd_i/rdata_o : read strobe, data registered one cycle later
//   capch_i      : asynchronous capture pins, one per channel
//   pwm_o        : registered compare outputs, one per channel
//   irq_o        : registered level interrupt
module tmr_mch #(
    parameter int CH_NUM     = 4,
    parameter int CNT_WIDTH  = 32,
    parameter int PSCR_WIDTH = 20
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [7:0]        addr_i,
    input  logic              wr_i,
    input  logic [31:0]       wdata_i,
    input  logic              rd_i,
    output logic [31:0]       rdata_o,
    input  logic [CH_NUM-1:0] capch_i,
    output logic [CH_NUM-1:0] pwm_o,
    output logic              irq_o
);
    import tmr_mch_pkg::*;

    logic                  en, osm, ovie, ovif;
    logic [PSCR_WIDTH-1:0] pscr, div, div_top;
    logic [CNT_WIDTH-1:0]  cnt, reload;
    logic                  tick, cnt_tick, wrap;

    logic [5:0]            word;
    logic                  ch_hit;
    logic [1:0]            ch_idx;
    logic                  ctrl_wr, pscr_wr, cnt_wr, reload_wr, stat_wr;

    logic [CH_NUM-1:0]     chctrl_wr, chval_wr, chif, ch_pwm, ch_irq;
    logic [2:0]            chctrl [CH_NUM];
    logic [CNT_WIDTH-1:0]  chval  [CH_NUM];
    logic [31:0]           rd_mux;

    // Byte-lane bits and write-data bits beyond the implemented widths
    logic                  unused_bits;
    assign unused_bits = ^{addr_i[1:0], wdata_i};

    assign word      = addr_i[7:2];
    assign ch_hit    = (addr_i[7:5] == ADDR_CH_BASE[7:5]);
    assign ch_idx    = addr_i[4:3];
    assign ctrl_wr   = wr_i && (word == ADDR_CTRL[7:2]);
    assign pscr_wr   = wr_i && (word == ADDR_PSCR[7:2]);
    assign cnt_wr    = wr_i && (word == ADDR_CNT[7:2]);
    assign reload_wr = wr_i && (word == ADDR_RELOAD[7:2]);
    assign stat_wr   = wr_i && (word == ADDR_STAT[7:2]);

    // PSCR=0 behaves as PSCR=1: terminal count 0, tick every enabled cycle
    assign div_top  = (pscr == '0) ? '0 : pscr - PSCR_WIDTH'(1);
    assign tick     = en && (div == div_top);
    // A software CNT write swallows a coincident tick entirely
    assign cnt_tick = tick && !cnt_wr;
    assign wrap     = cnt_tick && (cnt == reload);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            en      <= 1'b0;
            osm     <= 1'b0;
            ovie    <= 1'b0;
            pscr    <= '0;
            reload  <= '1;
            cnt     <= '0;
            div     <= '0;
            ovif    <= 1'b0;
            irq_o   <= 1'b0;
            rdata_o <= '0;
        end else begin
            if (ctrl_wr) begin
                en   <= wdata_i[CTRL_EN];
                osm  <= wdata_i[CTRL_OSM];
                ovie <= wdata_i[CTRL_OVIE];
            end
            // One-shot stop overrides a coincident CTRL write
            if (wrap && osm)
                en <= 1'b0;

            if (pscr_wr)
                pscr <= wdata_i[PSCR_WIDTH-1:0];
            if (reload_wr)
                reload <= wdata_i[CNT_WIDTH-1:0];

            // Prescaler restarts on CNT write, on enable rising, and at top
            if (cnt_wr || (ctrl_wr && wdata_i[CTRL_EN] && !en) || tick)
                div <= '0;
            else if (en)
                div <= div + PSCR_WIDTH'(1);

            if (cnt_wr)
                cnt <= wdata_i[CNT_WIDTH-1:0];
            else if (cnt_tick)
                cnt <= wrap ? '0 : cnt + CNT_WIDTH'(1);

            ovif <= (ovif & ~(stat_wr & wdata_i[0])) | wrap;

            irq_o   <= (ovif & ovie) | (|ch_irq);
            rdata_o <= rd_i ? rd_mux : '0;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (word)
            ADDR_CTRL[7:2]:   rd_mux = 32'({ovie, osm, en});
            ADDR_PSCR[7:2]:   rd_mux = 32'(pscr);
            ADDR_CNT[7:2]:    rd_mux = 32'(cnt);
            ADDR_RELOAD[7:2]: rd_mux = 32'(reload);
            ADDR_STAT[7:2]:   rd_mux = 32'({chif, ovif});
            default: begin
                if (ch_hit) begin
                    for (int n = 0; n < CH_NUM; n++) begin
                        if (ch_idx == 2'(n))
                            rd_mux = addr_i[2] ? 32'(chval[n]) : 32'(chctrl[n]);
                    end
                end
            end
        endcase
    end

    for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
        assign chctrl_wr[g] = wr_i && ch_hit && (ch_idx == 2'(g)) && !addr_i[2];
        assign chval_wr[g]  = wr_i && ch_hit && (ch_idx == 2'(g)) &&  addr_i[2];

        tmr_mch_ch #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_ch (
            .clk_i        (clk_i),
            .rst_i        (rst_i),
            .cnt_i        (cnt),
            .tick_i       (cnt_tick),
            .ctrl_wr_i    (chctrl_wr[g]),
            .ctrl_wdata_i (wdata_i[2:0]),
            .val_wr_i     (chval_wr[g]),
            .val_wdata_i  (wdata_i[CNT_WIDTH-1:0]),
            .flag_clr_i   (stat_wr && wdata_i[g+1]),
            .capch_i      (capch_i[g]),
            .chctrl_o     (chctrl[g]),
            .chval_o      (chval[g]),
            .chif_o       (chif[g]),
            .pwm_o        (ch_pwm[g]),
            .irq_o        (ch_irq[g])
        );
    end

    assign pwm_o = ch_pwm;

endmodule

// File: doc/tmr_mch.md
TMR_MCH -- requirements
Module: tmr_mch

Interface
REQ-001 SHALL have parameter CH_NUM, default 4, meaning number of capture/compare channels (legal 1..4).
REQ-002 SHALL have parameter CNT_WIDTH, default 32, meaning counter/reload/compare width (legal 8..32).
REQ-003 SHALL have parameter PSCR_WIDTH, default 20, meaning prescaler width (legal 1..24).
REQ-004 SHALL have port clk_i, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_i, input, 1; reset is synchronous and active-high.
REQ-006 SHALL have port addr_i, input, 8, byte address; bits [1:0] ignored.
REQ-007 SHALL have port wr_i, input, 1, write strobe, one access per cycle.
REQ-008 SHALL have port wdata_i, input, 32, write data.
REQ-009 SHALL have port rd_i, input, 1, read strobe.
REQ-010 SHALL have port rdata_o, output, 32, read data, valid the cycle after rd_i.
REQ-011 SHALL have port capch_i, input, CH_NUM, asynchronous capture pins.
REQ-012 SHALL have port pwm_o, output, CH_NUM, registered per-channel compare outputs.
REQ-013 SHALL have port irq_o, output, 1, registered level interrupt.

Function
REQ-014 SHALL decode: 0x00 CTRL {OVIE[2], OSM[1], EN[0]}; 0x04 PSCR; 0x08 CNT; 0x0C RELOAD; 0x10 STAT W1C {CHIF[CH_NUM:1], OVIF[0]}; 0x20+8n CHCTRL_n {IE[2], MODE[1:0]}; 0x24+8n CHVAL_n.
REQ-015 SHALL return zero for unmapped or unimplemented bits/channels and SHALL ignore writes to them.
REQ-016 SHALL run a prescaler div counting 0..max(PSCR,1)-1 while EN=1, with a one-cycle tick when div equals the top; PSCR=0 SHALL behave as PSCR=1 (tick every cycle).
REQ-017 SHALL, on tick, set CNT to 0 and OVIF to 1 when CNT==RELOAD, else increment CNT by 1.
REQ-018 SHALL clear EN at the wrap edge when OSM=1 (one-shot); CNT then holds 0.
REQ-019 SHALL hold div and CNT while EN=0; writing EN 0->1 SHALL restart div at 0.
REQ-020 SHALL give a software write to CNT priority over a simultaneous tick, and SHALL reset div to 0 on that write.
REQ-021 SHALL implement MODE 00 off, 01 compare, 10 capture-rise, 11 capture-fall.
REQ-022 SHALL, in compare mode, set CHIF_n on a tick where CNT==CHVAL_n, and drive pwm_o[n]=1 while CNT<CHVAL_n (registered, 1-cycle lag); pwm_o[n]=0 otherwise and in all other modes.
REQ-023 SHALL synchronise capch_i through two flops, then edge-detect; on a qualifying edge CHVAL_n SHALL load CNT and CHIF_n SHALL set, 3 cycles after the pin change.
REQ-024 SHALL let a capture in the same cycle as a software CHVAL_n write win.
REQ-025 SHALL let a hardware flag set win over a simultaneous W1C of the same bit.
REQ-026 SHALL drive irq_o = OR(OVIF&OVIE, CHIF_n&IE_n), registered one cycle.
REQ-027 SHALL compare only CNT_WIDTH bits; wider write data SHALL be truncated.

Reset
REQ-028 SHALL on rst_i clear all registers, div, synchronisers and edge detectors; RELOAD SHALL reset to all-ones; rdata_o, pwm_o, irq_o SHALL be 0 the cycle after reset.
REQ-029 SHALL abort counting and capture on reset mid-operation with no residual flag or pulse.

Structure
REQ-030 SHALL place register offsets, CTRL/CHCTRL bit indices and MODE enum in shared package tmr_mch_pkg.
REQ-031 SHALL instantiate sub-module tmr_mch_ch once per channel: compare, capture, synchroniser and flag logic.

Verification
REQ-032 SHALL cover: PSCR=3, RELOAD=4, EN=1 -> tick every 3 cycles; OVIF sets after 15 cycles; CNT wraps to 0.
REQ-033 SHALL cover: OSM=1, PSCR=1, RELOAD=2 -> exactly one OVIF, EN reads 0, CNT stays 0.
REQ-034 SHALL cover: ch0 compare CHVAL=2, RELOAD=5, PSCR=1 -> pwm_o[0] high 2 of 6 ticks; CHIF_1 sets; irq_o=1 only when IE=1.
REQ-035 SHALL cover: ch1 capture-rise, rising capch_i[1] at CNT=0x10, PSCR=1 -> CHVAL_1=0x13 (3-cycle latency), CHIF_2=1; falling edge ignored.
REQ-036 SHALL cover: STAT W1C of OVIF on the same edge as a wrap -> OVIF stays 1; a later W1C clears it and drops irq_o next cycle.
REQ-037 SHALL cover: CH_NUM=1, CNT_WIDTH=8 -> CNT write 0x1FF reads 0xFF; CHCTRL_1 reads 0.
